// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, oversampling constants, vote helper.
// Latency: none (types/constants only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MAJ_LO     = 4'd7;
  localparam logic [3:0] MAJ_MID    = 4'd8;
  localparam logic [3:0] MAJ_HI     = 4'd9;
  localparam logic [3:0] SC_LAST    = 4'(OVERSAMPLE - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with registered head data and overflow drop pulse.
// Latency: write-to-head 1 cycle; head updates the cycle after a pop.
// Backpressure: a write while full without a same-cycle pop is dropped and flagged.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  input  logic       rd_rdy,
  output logic       rd_vld,
  output logic [7:0] rd_dat,
  output logic       drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("byte_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_dat_q, rd_dat_d;
  logic          drop_q, drop_d;
  logic          full, empty, push, pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop      = rd_rdy && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    push     = wr_vld && (!full || pop);
    drop_d   = wr_vld && full && !pop;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rd_dat_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_dat_q <= '0;
      drop_q   <= 1'b0;
    end else if (ce) begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_dat_q <= rd_dat_d;
      drop_q   <= drop_d;
    end
  end

  assign rd_vld = (count_q != '0);
  assign rd_dat = rd_dat_q;
  assign drop   = drop_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling, 3-sample vote) feeding a byte FIFO.
// Latency: byte pushed at the mid-stop decision, data_valid one cycle later.
// Backpressure: consumer valid/ready; a full FIFO drops new bytes and pulses overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (OVERSAMPLE * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_fifo: CLK_FREQ / (16*BAUD) must be at least 2");
  end

  rx_state_t     state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic          fe_q, fe_d;
  logic          tick, vote;
  logic          push_vld;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sc_d     = sc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    fe_d     = 1'b0;
    push_vld = 1'b0;
    tick     = (div_q == DW'(DIV - 1));
    vote     = maj3(s7_q, s8_q, rx_s_q);

    div_d = tick ? '0 : div_q + DW'(1);
    if (tick) begin
      sc_d = sc_q + 4'd1;
      if (sc_q == MAJ_LO)  s7_d = rx_s_q;
      if (sc_q == MAJ_MID) s8_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        // Restart the bit clock on the falling edge so samples sit mid-bit.
        if (!rx_s_q) begin
          state_d = START;
          div_d   = '0;
          sc_d    = '0;
        end
      end
      START: begin
        if (tick && sc_q == MAJ_HI && vote) begin
          state_d = IDLE;
        end else if (tick && sc_q == SC_LAST) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick && sc_q == MAJ_HI) begin
          shreg_d = {vote, shreg_q[7:1]};
        end
        if (tick && sc_q == SC_LAST) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (tick && sc_q == MAJ_HI) begin
          if (vote) begin
            push_vld = 1'b1;
            state_d  = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      sc_q      <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      fe_q      <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      div_q     <= div_d;
      sc_q      <= sc_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      fe_q      <= fe_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .wr_vld (push_vld),
    .wr_dat (shreg_q),
    .rd_rdy (data_ready),
    .rd_vld (data_valid),
    .rd_dat (data_out),
    .drop   (overrun)
  );

  assign framing_error = fe_q;

endmodule
